// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// Also consumed by the control unit so both sides agree on the op field.
package mul_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_MUL    = 2'b01,
        S_DIV    = 2'b10,
        S_FINISH = 2'b11
    } state_e;

    // MULT and DIV are the signed variants (op[0] clear).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_datapath.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes.
// MULDIV_EARLY_TERM_EN: multiply finishes once the remaining multiplier is zero.
module mul_div_unit_datapath
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_mul,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH-1:0]     shr_o
);

    localparam int CW = $clog2(WIDTH);

    // acc: product (mul) or remainder in the low half (div).
    // opnd: shifted multiplicand (mul) or divisor (div).
    // shr: multiplier shifting right (mul) or dividend/quotient shifting left (div).
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0]   shr_q, shr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     partial;
    logic [WIDTH-1:0]   sub;
    logic               ge;

    always_comb begin
        partial = {acc_q[WIDTH-1:0], shr_q[WIDTH-1]};
        ge      = (partial >= {1'b0, opnd_q[WIDTH-1:0]});
        sub     = partial[WIDTH-1:0] - opnd_q[WIDTH-1:0];
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        shr_d   = shr_q;
        cnt_d   = cnt_q;
        if (load) begin
            acc_d = '0;
            cnt_d = '0;
            if (is_mul) begin
                opnd_d = {{WIDTH{1'b0}}, mag_a};
                shr_d  = mag_b;
            end else begin
                opnd_d = {{WIDTH{1'b0}}, mag_b};
                shr_d  = mag_a;
            end
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (is_mul) begin
                if (shr_q[0]) begin
                    acc_d = acc_q + opnd_q;
                end
                opnd_d = {opnd_q[2*WIDTH-2:0], 1'b0};
                shr_d  = {1'b0, shr_q[WIDTH-1:1]};
            end else if (ge) begin
                acc_d = {{WIDTH{1'b0}}, sub};
                shr_d = {shr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {{WIDTH{1'b0}}, partial[WIDTH-1:0]};
                shr_d = {shr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef MULDIV_EARLY_TERM_EN
    // Once no multiplier bits remain, later iterations would add nothing.
    assign last = (cnt_q == CW'(WIDTH - 1)) || (is_mul && (shr_q[WIDTH-1:1] == '0));
`else
    assign last = (cnt_q == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            shr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            shr_q  <= shr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc_o = acc_q;
    assign shr_o = shr_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS multiply/divide unit: FSM, sign handling and the architectural HI/LO registers.
// Optional MULDIV_EARLY_TERM_EN shortens multiplies (handled in the datapath).
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic               neg_a_q, neg_b_q, div0_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               start_ok, a_neg, b_neg, dp_load, dp_step, dp_is_mul, dp_last;
    logic [WIDTH-1:0]   mag_a, mag_b, dp_shr, quo_res, rem_res;
    logic [2*WIDTH-1:0] dp_acc, mul_res;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign a_neg     = op_is_signed(op) && src_a[WIDTH-1];
    assign b_neg     = op_is_signed(op) && src_b[WIDTH-1];
    assign mag_a     = a_neg ? -src_a : src_a;
    assign mag_b     = b_neg ? -src_b : src_b;
    assign dp_is_mul = (state_q == S_IDLE) ? ~op[1] : (state_q == S_MUL);

    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dp_load = 1'b1;
                    state_d = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                dp_step = 1'b1;
                if (dp_last) begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    mul_div_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dp_load),
        .step   (dp_step),
        .is_mul (dp_is_mul),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .last   (dp_last),
        .acc_o  (dp_acc),
        .shr_o  (dp_shr)
    );

    // Divide by zero keeps the all-ones quotient; the remainder fix-up restores src_a.
    assign mul_res = ((op_q == MD_MULT) && (neg_a_q ^ neg_b_q)) ? -dp_acc : dp_acc;
    assign quo_res = ((op_q == MD_DIV) && (neg_a_q ^ neg_b_q) && !div0_q) ? -dp_shr : dp_shr;
    assign rem_res = ((op_q == MD_DIV) && neg_a_q) ? -dp_acc[WIDTH-1:0] : dp_acc[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= MD_MULT;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FINISH);
            if (start_ok) begin
                op_q    <= op;
                neg_a_q <= a_neg;
                neg_b_q <= b_neg;
                div0_q  <= (src_b == '0);
            end
            if (state_q == S_FINISH) begin
                if (op_q[1]) begin
                    hi_q <= rem_res;
                    lo_q <= quo_res;
                end else begin
                    {hi_q, lo_q} <= mul_res;
                end
            end else if ((state_q == S_IDLE) && !start) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed MULT/MULTU/DIV/DIVU vectors,
// mthi/mtlo writes, start-while-busy and asynchronous reset mid-operation.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           start_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges from start to done: WIDTH iterations plus the FINISH cycle.
    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        logic [W-1:0] m;
        int n;
        m = (!o[0] && b[W-1]) ? -b : b;
        n = W;
`ifdef MULDIV_EARLY_TERM_EN
        if (!o[1]) begin
            n = 1;
            for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        end
`endif
        return n + 1;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual hi=0x%08h lo=0x%08h expected no done", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check_int({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
                $display("txn %s hi=0x%08h lo=0x%08h latency=%0d", e.name, hi, lo, cyc - e.start_cyc);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input string nm, input bit interfere);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        e.hi = exp_hi; e.lo = exp_lo; e.lat = exp_lat(o, b);
        e.start_cyc = cyc; e.name = nm;
        sb.push_back(e);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (interfere && busy_cnt == 5 && !seen) begin
                start = 1'b1; op = MD_DIVU; src_a = 32'h1234; src_b = 32'h3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBAD0BAD0;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no done expected done within 100 cycles", nm);
            void'(sb.pop_back());
        end
        check_int({nm, "_busy_cycles"}, busy_cnt, e.lat);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        hi_we = 1'b1; wdata = 32'h13;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h13);
        check("mthi_lo_kept", lo, 32'h0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_hi", hi, 32'h55);
        check("mthi_mtlo_lo", lo, 32'h55);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0);
        run_op(MD_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7", 1'b0);
        run_op(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin", 1'b0);
        run_op(MD_MULTU, 32'h3,        32'h5,        32'h0,        32'hF,        "multu_3x5", 1'b0);
        run_op(MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2", 1'b0);
        run_op(MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, "div_7byneg2", 1'b0);
        run_op(MD_DIVU,  32'h14,       32'h40,       32'h14,       32'h0,        "divu_small", 1'b0);
        run_op(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7", 1'b0);
        run_op(MD_DIVU,  32'h28,       32'h0,        32'h28,       32'hFFFFFFFF, "divu_by0", 1'b0);
        run_op(MD_DIV,   32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, "div_neg_by0", 1'b0);
        run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, "div_min_by_m1", 1'b0);

        // start and mthi together: the write is dropped.
        hi_we = 1'b1; wdata = 32'hDEAD;
        run_op(MD_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, "start_beats_mthi", 1'b0);
        // start/mthi/mtlo while busy are ignored.
        run_op(MD_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, "busy_ignores", 1'b1);

        // Asynchronous reset in the middle of a multiply.
        op = MD_MULTU; src_a = 32'h7; src_b = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(MD_MULTU, 32'h7, 32'hFFFFFFFF, 32'h6, 32'hFFFFFFF9, "after_abort", 1'b0);

        repeat (3) @(negedge clk);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
